// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the fetch port, the memory-stage port, the unified
//               memory port and the status outputs of mem_arbiter. The
//               slave modport is the arbiter's view. The master modport is
//               the view of the surrounding pipeline and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    // Fetch port
    logic        IReq;
    logic [31:0] IAddr;
    logic        IKill;
    logic [31:0] IRData;
    logic        IReady;
    // Memory-stage port
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic [31:0] DRData;
    logic        DReady;
    // Unified single-port memory
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
    // Pipeline stalls and status
    logic        StallF;
    logic        StallM;
    logic        Err;

    modport slave (
        input  IReq, IAddr, IKill, DReq, DWe, DAddr, DWData, MemRData, MemAck,
        output IRData, IReady, DRData, DReady, MemReq, MemWe, MemAddr, MemWData,
               StallF, StallM, Err
    );

    modport master (
        output IReq, IAddr, IKill, DReq, DWe, DAddr, DWData, MemRData, MemAck,
        input  IRData, IReady, DRData, DReady, MemReq, MemWe, MemAddr, MemWData,
               StallF, StallM, Err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a fetch port and a memory-stage port onto one
//               single-port memory. Data requests have priority, but a
//               waiting fetch is granted after STARVE_MAX back-to-back data
//               grants. A transaction with no MemAck after TIMEOUT cycles is
//               aborted, and the sticky Err flag is set.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_arbiter_if.slave       bus
);

    localparam int c_SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int c_CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_SW-1:0] c_STREAK_MAX = c_SW'(STARVE_MAX);
    localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IBUSY = 2'd1,
        S_DBUSY = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t          r_state;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_we;
    logic            r_kill;
    logic            r_err;
    logic [c_SW-1:0] r_streak;
    logic [c_CW-1:0] r_cnt;

    logic w_busy;
    logic w_grant_d;
    logic w_grant_i;
    logic w_timeout;
    logic w_iready;
    logic w_dready;

    // The grant decision is made only in IDLE, so there is always one idle
    // turnaround cycle between two transactions.
    assign w_busy    = (r_state == S_IBUSY) || (r_state == S_DBUSY);
    assign w_grant_d = (r_state == S_IDLE) && bus.DReq &&
                       !(bus.IReq && (r_streak == c_STREAK_MAX));
    assign w_grant_i = (r_state == S_IDLE) && !w_grant_d && bus.IReq;
    assign w_timeout = w_busy && !bus.MemAck && (r_cnt == c_CNT_LAST);

    // A redirect in the acknowledging cycle itself also suppresses the
    // fetch result, not only a redirect remembered in the kill flag.
    assign w_iready  = (r_state == S_IBUSY) && bus.MemAck && !r_kill && !bus.IKill;
    assign w_dready  = (r_state == S_DBUSY) && bus.MemAck;

    assign bus.MemReq   = w_busy;
    assign bus.MemWe    = (r_state == S_DBUSY) && r_we;
    assign bus.MemAddr  = r_addr;
    assign bus.MemWData = r_wdata;
    assign bus.IReady   = w_iready;
    assign bus.DReady   = w_dready;
    assign bus.IRData   = bus.MemRData;
    assign bus.DRData   = bus.MemRData;
    assign bus.StallF   = bus.IReq && !w_iready;
    assign bus.StallM   = bus.DReq && !w_dready;
    assign bus.Err      = r_err;

    // Arbitration FSM, request latches, starvation streak, timeout counter
    // and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_kill   <= 1'b0;
            r_err    <= 1'b0;
            r_streak <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_d) begin
                        r_state <= S_DBUSY;
                        r_addr  <= bus.DAddr;
                        r_wdata <= bus.DWData;
                        r_we    <= bus.DWe;
                    end else if (w_grant_i) begin
                        r_state <= S_IBUSY;
                        r_addr  <= bus.IAddr;
                        r_wdata <= '0;
                        r_we    <= 1'b0;
                        r_kill  <= bus.IKill;
                    end
                end
                S_IBUSY, S_DBUSY: begin
                    r_cnt <= r_cnt + c_CW'(1);
                    if (bus.MemAck) begin
                        r_state <= S_IDLE;
                        r_kill  <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= S_ABORT;
                        r_err   <= 1'b1;
                        r_kill  <= 1'b0;
                    end else if ((r_state == S_IBUSY) && bus.IKill) begin
                        r_kill  <= 1'b1;
                    end
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // The streak counts data grants won while a fetch waits. Any fetch
            // grant, or no pending fetch, clears the streak.
            if (!bus.IReq || w_grant_i) begin
                r_streak <= '0;
            end else if (w_grant_d && (r_streak != c_STREAK_MAX)) begin
                r_streak <= r_streak + c_SW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. It contains a
//               latency-programmable memory responder and ready-pulse
//               scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic        mem_en;
    int          mem_lat;
    logic        resp_ack;
    logic        inj_ack;
    int          resp_cyc;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    mem_arbiter_if bus();

    mem_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return 32'hE3A01005 ^ (a ^ 32'h0000_0100);
    endfunction

    assign bus.MemAck   = resp_ack | inj_ack;
    assign bus.MemRData = bus.MemAck ? rdata_of(bus.MemAddr) : 32'h0BAD_F00D;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_iready(input int budget, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            cyc();
            smp();
            if (bus.IReady) seen = 1'b1;
        end
    endtask

    task automatic wait_dready(input int budget, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            cyc();
            smp();
            if (bus.DReady) seen = 1'b1;
        end
    endtask

    // Memory responder: acknowledges in the mem_lat-th cycle of MemReq.
    initial begin
        resp_ack = 1'b0;
        resp_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.MemReq) resp_cyc++;
            else            resp_cyc = 0;
            resp_ack = bus.MemReq && mem_en && (resp_cyc == mem_lat);
        end
    end

    // Scoreboard: each ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (bus.IReady) begin
            checks++;
            assert (exp_i.size() != 0) else begin
                errors++;
                $error("FAIL sb_i_unexpected: observed IReady with data %h expected no pulse", bus.IRData);
            end
            if (exp_i.size() != 0) check32("sb_irdata", bus.IRData, exp_i.pop_front());
        end
        if (bus.DReady) begin
            checks++;
            assert (exp_d.size() != 0) else begin
                errors++;
                $error("FAIL sb_d_unexpected: observed DReady with data %h expected no pulse", bus.DRData);
            end
            if (exp_d.size() != 0) check32("sb_drdata", bus.DRData, exp_d.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic        seen;
        int          n_i;
        int          n_d;
        int          ng;
        logic [15:0] seq;
        logic        prev;

        checks = 0;
        errors = 0;
        mem_en = 1'b1;
        mem_lat = 2;
        inj_ack = 1'b0;
        reset = 1'b1;
        bus.IReq = 1'b0; bus.IAddr = '0; bus.IKill = 1'b0;
        bus.DReq = 1'b0; bus.DWe = 1'b0; bus.DAddr = '0; bus.DWData = '0;

        // Reset state
        smp();
        check32("rst_memreq", bus.MemReq, 1'b0);
        check32("rst_memwe", bus.MemWe, 1'b0);
        check32("rst_memaddr", bus.MemAddr, 32'h0);
        check32("rst_memwdata", bus.MemWData, 32'h0);
        check32("rst_err", bus.Err, 1'b0);
        check32("rst_iready", bus.IReady, 1'b0);
        check32("rst_dready", bus.DReady, 1'b0);
        cyc(); reset = 1'b0;
        smp();

        // Fetch only, MemAck two cycles after MemReq
        cyc(); bus.IReq = 1'b1; bus.IAddr = 32'h100; exp_i.push_back(32'hE3A01005);
        smp();
        check32("f_idle_memreq", bus.MemReq, 1'b0);
        check32("f_idle_stallf", bus.StallF, 1'b1);
        cyc(); smp();
        check32("f_b1_memreq", bus.MemReq, 1'b1);
        check32("f_b1_memaddr", bus.MemAddr, 32'h100);
        check32("f_b1_memwe", bus.MemWe, 1'b0);
        check32("f_b1_iready", bus.IReady, 1'b0);
        cyc(); smp();
        check32("f_b2_memreq", bus.MemReq, 1'b1);
        check32("f_b2_iready", bus.IReady, 1'b1);
        check32("f_b2_irdata", bus.IRData, 32'hE3A01005);
        check32("f_b2_stallf", bus.StallF, 1'b0);
        cyc(); bus.IReq = 1'b0;
        smp();
        check32("f_done_memreq", bus.MemReq, 1'b0);

        // Simultaneous store and fetch: data first, turnaround, then fetch
        cyc(); mem_lat = 1;
        bus.IReq = 1'b1; bus.IAddr = 32'h140;
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h200; bus.DWData = 32'hAB;
        exp_d.push_back(rdata_of(32'h200)); exp_i.push_back(rdata_of(32'h140));
        smp();
        check32("s_idle_memreq", bus.MemReq, 1'b0);
        cyc(); smp();
        check32("s_d_memreq", bus.MemReq, 1'b1);
        check32("s_d_memwe", bus.MemWe, 1'b1);
        check32("s_d_memaddr", bus.MemAddr, 32'h200);
        check32("s_d_memwdata", bus.MemWData, 32'hAB);
        check32("s_d_dready", bus.DReady, 1'b1);
        check32("s_d_stallm", bus.StallM, 1'b0);
        check32("s_d_stallf", bus.StallF, 1'b1);
        cyc(); bus.DReq = 1'b0; bus.DWe = 1'b0;
        smp();
        check32("s_turn_memreq", bus.MemReq, 1'b0);
        check32("s_turn_memwe", bus.MemWe, 1'b0);
        cyc(); smp();
        check32("s_i_memreq", bus.MemReq, 1'b1);
        check32("s_i_memaddr", bus.MemAddr, 32'h140);
        check32("s_i_memwe", bus.MemWe, 1'b0);
        check32("s_i_iready", bus.IReady, 1'b1);
        cyc(); bus.IReq = 1'b0;
        smp();

        // Stray MemAck and IKill in IDLE have no effect
        cyc(); inj_ack = 1'b1; bus.IKill = 1'b1;
        smp();
        check32("idle_ack_iready", bus.IReady, 1'b0);
        check32("idle_ack_dready", bus.DReady, 1'b0);
        cyc(); inj_ack = 1'b0; bus.IKill = 1'b0;
        mem_lat = 2; bus.IReq = 1'b1; bus.IAddr = 32'h340; exp_i.push_back(rdata_of(32'h340));
        smp();
        check32("idle_ack_memreq", bus.MemReq, 1'b0);
        wait_iready(6, seen);
        check32("idle_kill_fetch_seen", seen, 1'b1);
        cyc(); bus.IReq = 1'b0;
        smp();

        // Starvation: four data grants, then the fetch, twice over
        cyc(); mem_lat = 1;
        bus.IReq = 1'b1; bus.IAddr = 32'h180;
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h240;
        for (int k = 0; k < 9; k++) exp_d.push_back(rdata_of(32'h240));
        for (int k = 0; k < 2; k++) exp_i.push_back(rdata_of(32'h180));
        n_i = 0; n_d = 0; ng = 0; seq = '0; prev = 1'b0;
        for (int k = 0; k < 100 && n_d < 9; k++) begin
            smp();
            if (bus.MemReq && !prev) begin
                seq = {seq[14:0], (bus.MemAddr == 32'h240)};
                ng++;
            end
            prev = bus.MemReq;
            if (bus.IReady) n_i++;
            if (bus.DReady) n_d++;
            cyc();
            if (n_i == 2) bus.IReq = 1'b0;
            if (n_d == 9) bus.DReq = 1'b0;
        end
        check32("starve_grant_order", seq, 16'h07BD);
        check32("starve_grant_count", ng, 11);
        check32("starve_fetch_done", n_i, 2);
        check32("starve_data_done", n_d, 9);
        smp();

        // Kill during IBUSY suppresses IReady; the redirected fetch is served
        cyc(); mem_lat = 3; bus.IReq = 1'b1; bus.IAddr = 32'h2C0;
        smp();
        cyc(); bus.IKill = 1'b1;
        smp();
        check32("k_b1_memreq", bus.MemReq, 1'b1);
        check32("k_b1_memaddr", bus.MemAddr, 32'h2C0);
        cyc(); bus.IKill = 1'b0;
        smp();
        check32("k_b2_iready", bus.IReady, 1'b0);
        cyc(); smp();
        check32("k_ack_memreq", bus.MemReq, 1'b1);
        check32("k_ack_iready", bus.IReady, 1'b0);
        check32("k_ack_stallf", bus.StallF, 1'b1);
        cyc(); bus.IAddr = 32'h300; exp_i.push_back(rdata_of(32'h300));
        smp();
        check32("k_turn_memreq", bus.MemReq, 1'b0);
        cyc(); smp();
        check32("k_re_memreq", bus.MemReq, 1'b1);
        check32("k_re_memaddr", bus.MemAddr, 32'h300);
        wait_iready(6, seen);
        check32("k_re_seen", seen, 1'b1);
        check32("k_re_irdata", bus.IRData, rdata_of(32'h300));
        cyc(); bus.IReq = 1'b0;
        smp();

        // Timeout: eight busy cycles, ABORT, sticky Err, re-grant
        cyc(); mem_en = 1'b0; bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h400;
        exp_d.push_back(rdata_of(32'h400));
        smp();
        check32("t_idle_err", bus.Err, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cyc(); smp();
            check32("t_busy_memreq", bus.MemReq, 1'b1);
            check32("t_busy_err", bus.Err, 1'b0);
        end
        cyc(); mem_en = 1'b1; mem_lat = 2;
        smp();
        check32("t_abort_memreq", bus.MemReq, 1'b0);
        check32("t_abort_err", bus.Err, 1'b1);
        check32("t_abort_dready", bus.DReady, 1'b0);
        cyc(); smp();
        check32("t_idle2_memreq", bus.MemReq, 1'b0);
        cyc(); smp();
        check32("t_regrant_memreq", bus.MemReq, 1'b1);
        check32("t_regrant_memaddr", bus.MemAddr, 32'h400);
        check32("t_regrant_err", bus.Err, 1'b1);
        cyc(); smp();
        check32("t_regrant_dready", bus.DReady, 1'b1);
        cyc(); bus.DReq = 1'b0;
        smp();
        check32("t_sticky_err", bus.Err, 1'b1);

        // Reset in DBUSY: abandoned without DReady, re-granted right after release
        cyc(); mem_lat = 3;
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h500; bus.DWData = 32'h55;
        smp();
        cyc(); smp();
        check32("r_busy_memreq", bus.MemReq, 1'b1);
        check32("r_busy_memwe", bus.MemWe, 1'b1);
        cyc(); reset = 1'b1;
        #1;
        check32("r_async_memreq", bus.MemReq, 1'b0);
        check32("r_async_memwe", bus.MemWe, 1'b0);
        check32("r_async_err", bus.Err, 1'b0);
        check32("r_async_memaddr", bus.MemAddr, 32'h0);
        smp();
        check32("r_held_dready", bus.DReady, 1'b0);
        cyc(); reset = 1'b0; exp_d.push_back(rdata_of(32'h500));
        smp();
        check32("r_rel_memreq", bus.MemReq, 1'b0);
        cyc(); smp();
        check32("r_regrant_memreq", bus.MemReq, 1'b1);
        check32("r_regrant_memwe", bus.MemWe, 1'b1);
        check32("r_regrant_memaddr", bus.MemAddr, 32'h500);
        check32("r_regrant_memwdata", bus.MemWData, 32'h55);
        wait_dready(6, seen);
        check32("r_regrant_seen", seen, 1'b1);
        cyc(); bus.DReq = 1'b0; bus.DWe = 1'b0;
        smp();

        check32("sb_i_drained", exp_i.size(), 0);
        check32("sb_d_drained", exp_d.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while a fetch waits.
REQ-002 Parameter TIMEOUT, default 255: max cycles from grant to MemAck before abort.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 IReq  in  1  fetch request; held with IAddr until IReady.
REQ-006 IAddr  in  32  fetch word address.
REQ-007 IKill  in  1  fetch redirect (branch taken); discards in-flight fetch result.
REQ-008 IRData  out  32  fetch read data, valid when IReady.
REQ-009 IReady  out  1  one-cycle fetch completion pulse.
REQ-010 DReq, DWe  in  1 each  memory-stage request and write-enable; held with DAddr/DWData until DReady.
REQ-011 DAddr, DWData  in  32 each  data address and store data.
REQ-012 DRData  out  32  load data, valid when DReady.
REQ-013 DReady  out  1  one-cycle data completion pulse.
REQ-014 MemReq, MemWe  out  1 each  unified single-port memory request and write-enable.
REQ-015 MemAddr, MemWData  out  32 each  memory address and write data.
REQ-016 MemRData  in  32  memory read data, valid with MemAck.
REQ-017 MemAck  in  1  memory completion, one cycle, any latency >= 1 after MemReq rises.
REQ-018 StallF, StallM  out  1 each  pipeline stalls for fetch and memory stages.
REQ-019 Err  out  1  sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, IBUSY, DBUSY, ABORT.
REQ-021 IDLE: if DReq and not (IReq and DStreak==STARVE_MAX) -> DBUSY; else if IReq -> IBUSY; else stay.
REQ-022 On grant, address, write data and DWe SHALL be latched; memory outputs driven only from latches.
REQ-023 MemReq SHALL be 1 exactly in IBUSY/DBUSY; MemWe = latched DWe in DBUSY, else 0.
REQ-024 In a BUSY state with MemAck=1, the FSM SHALL return to IDLE; one turnaround cycle between transactions is mandatory.
REQ-025 IReady = MemAck in IBUSY and not killed; DReady = MemAck in DBUSY; both combinational from MemAck.
REQ-026 IRData and DRData SHALL equal MemRData (pass-through).
REQ-027 DStreak SHALL increment (saturating at STARVE_MAX) on data grant while IReq=1, and clear on any fetch grant or while IReq=0.
REQ-028 IKill in IBUSY, or in the IDLE-to-IBUSY grant cycle, SHALL set a kill flag; the fetch completes on the memory but IReady stays 0; flag clears on leaving IBUSY.
REQ-029 IKill in IDLE with no fetch granted SHALL have no effect.
REQ-030 StallF = IReq and not IReady; StallM = DReq and not DReady.
REQ-031 A cycle counter SHALL clear on grant and increment in BUSY; reaching TIMEOUT without MemAck -> ABORT.
REQ-032 ABORT: MemReq=0, Err set, one cycle, then IDLE; no Ready pulse for the aborted request, which is re-arbitrated if still requested.
REQ-033 MemAck in IDLE or ABORT SHALL be ignored.
REQ-034 Stores and loads SHALL use identical timing; DWe does not alter arbitration.

Reset
REQ-035 Reset asserted SHALL immediately force IDLE, kill flag 0, DStreak 0, timeout counter 0, Err 0, MemReq 0, MemWe 0, IReady 0, DReady 0, latched address/data 0.
REQ-036 Reset mid-transaction SHALL abandon it with no Ready pulse; the first grant is possible in the first cycle after reset deasserts.

Verification
REQ-037 Fetch only: IReq=1, IAddr=0x100, MemAck 2 cycles after MemReq, MemRData=0xE3A01005 -> MemReq 2 cycles, IReady pulse with IRData=0xE3A01005, StallF=0 that cycle.
REQ-038 Simultaneous: IReq and DReq (DWe=1, DAddr=0x200, DWData=0xAB) in IDLE -> DBUSY first, MemWe=1, MemAddr=0x200, then IDLE, then IBUSY.
REQ-039 Starvation: IReq held, DReq re-asserted after every DReady, STARVE_MAX=4 -> exactly 4 data grants, then fetch grant, DStreak cleared.
REQ-040 Kill: IKill pulse during IBUSY -> MemAck produces no IReady; next IDLE re-grants fetch at new IAddr=0x300.
REQ-041 Timeout: TIMEOUT=8, MemAck never sent -> ABORT on cycle 8, Err=1 sticky, request re-granted.
REQ-042 Reset in DBUSY: assert reset -> MemReq=0 at once, DReady never pulses, DBUSY re-granted first cycle after release.
